// File: rtl/key_capture.sv
// key_capture: synchronizes and debounces four push-buttons and latches a
// one-hot record of the most recently pressed key for a 4-to-2 encoder.
// A press is a debounced 0->1 transition. Releases never change the selection.
// Simultaneous presses resolve to the highest key index.
module key_capture #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_in,
    input  logic       clr,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    output logic       valid,
    output logic       press_pulse
);

    // Counter value seen on the last differing sample before the level is accepted.
    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    // Synchronizer, debounce and capture state
    logic [3:0] s1_q;
    logic [3:0] s2_q;
    logic [3:0] db_q;
    logic [3:0] db_d;
    logic [3:0] db_prev_q;
    logic [7:0] cnt_q [4];
    logic [7:0] cnt_d [4];
    logic [3:0] sel_q;
    logic [3:0] sel_d;
    logic       valid_q;
    logic       valid_d;
    logic       pulse_q;
    logic       pulse_d;
    logic [3:0] press_s;

    // Priority pick of the highest-index press event, returned one-hot.
    function automatic logic [3:0] pick_highest(input logic [3:0] ev);
        logic [3:0] r;
        casez (ev)
            4'b1???: r = 4'b1000;
            4'b01??: r = 4'b0100;
            4'b001?: r = 4'b0010;
            4'b0001: r = 4'b0001;
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

    // Debounce next state: count consecutive samples that disagree with db,
    // accept the new level on the last one, restart on any agreeing sample.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = 8'd0;
            if (s2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    db_d[i]  = s2_q[i];
                    cnt_d[i] = 8'd0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 8'd1;
                end
            end else begin
                cnt_d[i] = 8'd0;
            end
        end
    end

    // A press event is a debounced level that rose on the previous edge.
    assign press_s = db_q & ~db_prev_q;

    // Capture next state: clear beats a press; releases and idle cycles hold.
    always_comb begin
        sel_d   = sel_q;
        valid_d = valid_q;
        pulse_d = 1'b0;
        if (clr) begin
            sel_d   = 4'b0000;
            valid_d = 1'b0;
            pulse_d = 1'b0;
        end else if (|press_s) begin
            sel_d   = pick_highest(press_s);
            valid_d = 1'b1;
            pulse_d = 1'b1;
        end else begin
            sel_d   = sel_q;
            valid_d = valid_q;
            pulse_d = 1'b0;
        end
    end

    // State registers; reset clears everything including partial debounce counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= 4'b0000;
            s2_q      <= 4'b0000;
            db_q      <= 4'b0000;
            db_prev_q <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= 8'd0;
            end
            sel_q     <= 4'b0000;
            valid_q   <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            s1_q      <= key_in;
            s2_q      <= s1_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            sel_q     <= sel_d;
            valid_q   <= valid_d;
            pulse_q   <= pulse_d;
        end
    end

    assign A           = sel_q[0];
    assign B           = sel_q[1];
    assign C           = sel_q[2];
    assign D           = sel_q[3];
    assign valid       = valid_q;
    assign press_pulse = pulse_q;

endmodule
